// File: rtl/cmult_seq_pkg.sv
// Shared definitions for the time-multiplexed complex multiplier:
// default word/fraction widths, FSM state encoding and step indices.
package cmult_seq_pkg;

  localparam int N_DEF = 16;
  localparam int Q_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  // Step order: real part first (ar*br, then -ai*bi'), imaginary second.
  localparam step_t STEP_RR = 2'd0;  // pr  = m(ar, br)
  localparam step_t STEP_II = 2'd1;  // pr -= m(ai, bi')
  localparam step_t STEP_RI = 2'd2;  // pi  = m(ar, bi')
  localparam step_t STEP_IR = 2'd3;  // pi += m(ai, br)

endpackage

// File: rtl/cmult_seq_mult.sv
// fx_mult_sm: combinational Q-format multiplier. Two's-complement operands
// are converted to sign-magnitude, the magnitudes multiplied and shifted
// right by Q (truncation toward zero), the low N-1 magnitude bits kept
// (wrapping on overflow) and the result converted back. The most negative
// operand has no magnitude and is treated as zero.
module fx_mult_sm #(
  parameter int N = 16,
  parameter int Q = 9
) (
  input  logic signed [N-1:0] i_x,
  input  logic signed [N-1:0] i_y,
  output logic signed [N-1:0] o_p
);

  localparam logic signed [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic [N-2:0]       w_mag_x;
  logic [N-2:0]       w_mag_y;
  logic [2*N-3:0]     w_prod;
  logic [2*N-3:0]     w_shift;
  logic [N-2:0]       w_mag_p;
  logic signed [N-1:0] w_pos;
  logic               w_neg;

  function automatic logic [N-2:0] to_mag(input logic signed [N-1:0] v);
    logic signed [N-1:0] a;
    if (v == MOST_NEG) return '0;
    a = v[N-1] ? -v : v;
    return a[N-2:0];
  endfunction

  assign w_mag_x = to_mag(i_x);
  assign w_mag_y = to_mag(i_y);
  assign w_prod  = {{(N-1){1'b0}}, w_mag_x} * {{(N-1){1'b0}}, w_mag_y};
  assign w_shift = w_prod >> Q;
  assign w_mag_p = w_shift[N-2:0];
  assign w_neg   = i_x[N-1] ^ i_y[N-1];
  assign w_pos   = {1'b0, w_mag_p};

  // Back to two's complement; a zero magnitude always yields +0.
  always_comb begin
    o_p = '0;
    if (w_mag_p != '0) o_p = w_neg ? -w_pos : w_pos;
  end

endmodule

// File: rtl/cmult_seq.sv
// cmult_seq: one complex product per transaction using a single shared
// real multiplier over four cycles (one result every five cycles).
module cmult_seq
  import cmult_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] ar,
  input  logic signed [N-1:0] ai,
  input  logic signed [N-1:0] br,
  input  logic signed [N-1:0] bi,
  input  logic                conj_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] pr,
  output logic signed [N-1:0] pi
);

  localparam logic signed [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t              r_state;
  state_t              w_state_nxt;
  step_t               r_step;
  step_t               w_step_nxt;
  logic                w_accept;

  logic signed [N-1:0] r_ar;
  logic signed [N-1:0] r_ai;
  logic signed [N-1:0] r_br;
  logic signed [N-1:0] r_bi;
  logic                r_conj;
  logic signed [N-1:0] w_bi_eff;

  logic signed [N-1:0] w_mx;
  logic signed [N-1:0] w_my;
  logic signed [N-1:0] w_m;
  logic signed [N-1:0] r_pr;
  logic signed [N-1:0] r_pi;

  // Negation for conj(B); the most negative value has no magnitude and maps to 0.
  function automatic logic signed [N-1:0] neg_nomag(input logic signed [N-1:0] v);
    if (v == MOST_NEG) return '0;
    return -v;
  endfunction

  assign w_bi_eff = r_conj ? neg_nomag(r_bi) : r_bi;

  // Next-state and handshake decode; out_valid depends on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_state_nxt = ST_MUL;
          w_step_nxt  = STEP_RR;
        end
      end
      ST_MUL: begin
        w_step_nxt = r_step + 2'd1;
        if (r_step == STEP_IR) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        w_accept  = in_valid & out_ready;
        if (out_ready) begin
          w_state_nxt = in_valid ? ST_MUL : ST_IDLE;
          w_step_nxt  = STEP_RR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = STEP_RR;
      end
    endcase
  end

  // FSM state and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_RR;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Operand capture on accept; inputs are ignored at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar   <= '0;
      r_ai   <= '0;
      r_br   <= '0;
      r_bi   <= '0;
      r_conj <= 1'b0;
    end else if (w_accept) begin
      r_ar   <= ar;
      r_ai   <= ai;
      r_br   <= br;
      r_bi   <= bi;
      r_conj <= conj_b;
    end
  end

  // Operand routing to the shared multiplier for the current step.
  always_comb begin
    w_mx = r_ar;
    w_my = r_br;
    case (r_step)
      STEP_RR: begin w_mx = r_ar; w_my = r_br;     end
      STEP_II: begin w_mx = r_ai; w_my = w_bi_eff; end
      STEP_RI: begin w_mx = r_ar; w_my = w_bi_eff; end
      STEP_IR: begin w_mx = r_ai; w_my = r_br;     end
      default: begin w_mx = r_ar; w_my = r_br;     end
    endcase
  end

  fx_mult_sm #(.N(N), .Q(Q)) u_mult (
    .i_x (w_mx),
    .i_y (w_my),
    .o_p (w_m)
  );

  // Accumulators: wrap-around add/sub, written only while multiplying.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr <= '0;
      r_pi <= '0;
    end else if (r_state == ST_MUL) begin
      case (r_step)
        STEP_RR: r_pr <= w_m;
        STEP_II: r_pr <= r_pr - w_m;
        STEP_RI: r_pi <= w_m;
        STEP_IR: r_pi <= r_pi + w_m;
        default: r_pr <= r_pr;
      endcase
    end
  end

  assign pr = r_pr;
  assign pi = r_pi;

endmodule

// File: tb/tb_cmult_seq.sv
// Testbench for cmult_seq: directed products, back-to-back, backpressure,
// mid-operation reset and a randomised run against a reference model.
module tb_cmult_seq;

  localparam int N = 16;
  localparam int Q = 9;
  localparam logic [N-1:0] MOST_NEG = 16'h8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, conj_b, out_valid, out_ready;
  logic [N-1:0] ar, ai, br, bi, pr, pi;

  cmult_seq #(.N(N), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .conj_b    (conj_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pr        (pr),
    .pi        (pi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference multiplier built on integer arithmetic.
  function automatic logic [N-1:0] m_ref(input logic [N-1:0] x, input logic [N-1:0] y);
    longint ax, ay, p;
    ax = (x == MOST_NEG) ? 0 : (x[N-1] ? (longint'(1) << N) - longint'(x) : longint'(x));
    ay = (y == MOST_NEG) ? 0 : (y[N-1] ? (longint'(1) << N) - longint'(y) : longint'(y));
    p  = (ax * ay) / (longint'(1) << Q);
    p  = p % (longint'(1) << (N - 1));
    if (p == 0) return '0;
    return (x[N-1] ^ y[N-1]) ? N'((longint'(1) << N) - p) : N'(p);
  endfunction

  task automatic cmult_ref(input logic [N-1:0] xar, xai, xbr, xbi, input logic cj,
                           output logic [N-1:0] opr, output logic [N-1:0] opi);
    logic [N-1:0] bie;
    bie = xbi;
    if (cj) bie = (xbi == MOST_NEG) ? '0 : N'(~xbi + 1'b1);
    opr = m_ref(xar, xbr) - m_ref(xai, bie);
    opi = m_ref(xar, bie) + m_ref(xai, xbr);
  endtask

  // Scoreboard state
  logic [N-1:0] exp_pr_q[$];
  logic [N-1:0] exp_pi_q[$];
  int           acc_cyc_q[$];
  int           cyc = 0;
  bit           prev_hold = 0;
  logic [N-1:0] hold_pr, hold_pi, last_pr, last_pi;
  int           last_out_cyc = -1;
  bit           b2b_mode = 0, chk_rst = 0, last_acc = 0;
  int           n_acc = 0, n_out = 0;

  // One cycle: inputs already set after a falling edge; monitor at +1, then
  // advance to the next falling edge.
  task automatic cycle();
    logic [N-1:0] epr, epi;
    #1;
    last_acc = 0;
    if (rst) begin
      n_acc -= exp_pr_q.size();
      exp_pr_q.delete(); exp_pi_q.delete(); acc_cyc_q.delete();
      prev_hold = 0;
      last_out_cyc = -1;
    end else begin
      if (chk_rst) begin
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_pr", pr, 0);
        check("rst_pi", pi, 0);
        chk_rst = 0;
      end
      if (out_valid) begin
        if (prev_hold) begin
          check("hold_pr", pr, hold_pr);
          check("hold_pi", pi, hold_pi);
        end else begin
          check("out_expected", 32'(exp_pr_q.size()), 1);
          if (exp_pr_q.size() != 0) begin
            check("pr", pr, exp_pr_q[0]);
            check("pi", pi, exp_pi_q[0]);
            check("latency", 32'(cyc - acc_cyc_q[0]), 5);
            if (b2b_mode && last_out_cyc >= 0) check("spacing", 32'(cyc - last_out_cyc), 5);
            last_out_cyc = cyc;
          end
        end
        if (out_ready) begin
          if (exp_pr_q.size() != 0) begin
            void'(exp_pr_q.pop_front()); void'(exp_pi_q.pop_front()); void'(acc_cyc_q.pop_front());
          end
          last_pr = pr; last_pi = pi;
          n_out++;
          prev_hold = 0;
        end else begin
          check("bp_in_ready", in_ready, 0);
          prev_hold = 1; hold_pr = pr; hold_pi = pi;
        end
      end else begin
        prev_hold = 0;
        if (exp_pr_q.size() != 0) check("mul_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        cmult_ref(ar, ai, br, bi, conj_b, epr, epi);
        exp_pr_q.push_back(epr); exp_pi_q.push_back(epi); acc_cyc_q.push_back(cyc);
        last_acc = 1;
        n_acc++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_ops(input logic [N-1:0] xar, xai, xbr, xbi, input logic cj);
    ar = xar; ai = xai; br = xbr; bi = xbi; conj_b = cj;
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    do v = N'($urandom); while (v == MOST_NEG);
    return v;
  endfunction

  task automatic drain_all(input int budget);
    int guard = 0;
    while (exp_pr_q.size() != 0 && guard < budget) begin cycle(); guard++; end
    check("drained", 32'(exp_pr_q.size()), 0);
  endtask

  // Single transaction; operand inputs are scrambled right after accept.
  task automatic run_one(input logic [N-1:0] xar, xai, xbr, xbi, input logic cj);
    int guard = 0;
    set_ops(xar, xai, xbr, xbi, cj);
    in_valid = 1; out_ready = 1;
    do begin cycle(); guard++; end while (!last_acc && guard < 20);
    check("accepted", last_acc, 1);
    in_valid = 0;
    set_ops(rand_op(), rand_op(), rand_op(), rand_op(), ~cj);
    drain_all(30);
  endtask

  logic [N-1:0] b2b_ops [3][4];

  initial begin
    int idx, guard;
    rst = 1; in_valid = 0; out_ready = 0;
    set_ops('0, '0, '0, '0, 1'b0);
    cycle(); cycle();
    rst = 0; chk_rst = 1;
    cycle();

    run_one(16'h0500, 16'h0200, 16'h0200, 16'h0100, 1'b0);
    check("basic_pr", last_pr, 16'h0400);
    check("basic_pi", last_pi, 16'h0480);
    run_one(16'h0500, 16'h0200, 16'h0200, 16'h0100, 1'b1);
    check("conj_pr", last_pr, 16'h0600);
    check("conj_pi", last_pi, 16'hFF80);
    run_one(16'hFF00, 16'h0000, 16'h0000, 16'h0200, 1'b0);
    check("sign_pr", last_pr, 16'h0000);
    check("sign_pi", last_pi, 16'hFF00);
    run_one(16'h0003, 16'h0000, 16'hFF55, 16'h0000, 1'b0);
    check("trunc_pr", last_pr, 16'hFFFF);
    check("trunc_pi", last_pi, 16'h0000);

    // Back-to-back: three transactions, no bubbles.
    b2b_ops[0] = '{16'h0100, 16'hFF00, 16'h0280, 16'h0040};
    b2b_ops[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    b2b_ops[2] = '{16'hFE00, 16'h0123, 16'hF00D, 16'h0ABC};
    b2b_mode = 1; last_out_cyc = -1; idx = 0; guard = 0;
    set_ops(b2b_ops[0][0], b2b_ops[0][1], b2b_ops[0][2], b2b_ops[0][3], 1'b0);
    in_valid = 1; out_ready = 1;
    while (idx < 3 && guard < 40) begin
      cycle(); guard++;
      if (last_acc) begin
        idx++;
        if (idx < 3) set_ops(b2b_ops[idx][0], b2b_ops[idx][1], b2b_ops[idx][2], b2b_ops[idx][3], idx[0]);
        else in_valid = 0;
      end
    end
    check("b2b_accepts", 32'(idx), 3);
    in_valid = 0;
    drain_all(30);
    b2b_mode = 0;

    // Backpressure: hold out_ready low; a second request waits upstream.
    set_ops(16'h0321, 16'hFCDE, 16'h0456, 16'hFBA9, 1'b1);
    in_valid = 1; out_ready = 0; guard = 0;
    do begin cycle(); guard++; end while (!last_acc && guard < 20);
    check("bp_accepted", last_acc, 1);
    set_ops(16'h0111, 16'h0222, 16'hFEEE, 16'h0333, 1'b0);
    for (int k = 0; k < 12; k++) cycle();
    check("bp_pending", 32'(exp_pr_q.size()), 1);
    out_ready = 1; guard = 0;
    while ((in_valid || exp_pr_q.size() != 0) && guard < 30) begin
      cycle(); guard++;
      if (last_acc) in_valid = 0;
    end
    check("bp_done", 32'(exp_pr_q.size()), 0);
    in_valid = 0;

    // Reset during step 2.
    set_ops(16'h0500, 16'h0200, 16'h0200, 16'h0100, 1'b0);
    in_valid = 1; out_ready = 1;
    cycle();
    check("rst_accepted", last_acc, 1);
    in_valid = 0;
    cycle(); cycle();
    rst = 1; cycle();
    rst = 0; chk_rst = 1;
    cycle();
    run_one(16'h0500, 16'h0200, 16'h0200, 16'h0100, 1'b1);
    check("post_rst_pr", last_pr, 16'h0600);
    check("post_rst_pi", last_pi, 16'hFF80);

    // Randomised traffic with valid/ready gaps.
    begin
      int target;
      target = n_acc + 10000;
      guard = 0;
      in_valid = 0;
      while (n_acc < target && guard < 75000) begin
        if (!in_valid || last_acc) begin
          in_valid = ($urandom_range(0, 7) != 0);
          set_ops(rand_op(), rand_op(), rand_op(), rand_op(), 1'($urandom));
        end
        out_ready = ($urandom_range(0, 7) != 0);
        cycle(); guard++;
      end
      check("rand_target", 32'(n_acc >= target), 1);
      in_valid = 0; out_ready = 1;
      drain_all(30);
    end
    check("no_loss", 32'(n_out), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
